// File: rtl/com_pkg.sv
// ---------------------------------------------------------------------------
// com_pkg
// Shared definitions for the com_cs send path: bag type codes, field widths
// and the state encoding of the send arbiter FSM.
// ---------------------------------------------------------------------------
package com_pkg;

    localparam int BTYPE_W = 4;
    localparam int LEN_W   = 12;
    localparam int ADDR_W  = 12;

    localparam logic [BTYPE_W-1:0] BAG_ACK = 4'b0001;
    localparam logic [BTYPE_W-1:0] BAG_NAK = 4'b0010;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT     = 3'd1,
        ST_PICK     = 3'd2,
        ST_LATCH    = 3'd3,
        ST_SEND     = 3'd4,
        ST_DROP     = 3'd5,
        ST_REQ_DONE = 3'd6
    } send_state_e;

endpackage

// File: rtl/com_send_arb_if.sv
// ---------------------------------------------------------------------------
// com_send_arb_if
// The com_cs send channel: four-phase fs_send/fd_send handshake plus the
// packet descriptor sampled by com_cs.
//   master : arbiter side (drives fs_send and the descriptor, reads fd_send)
//   slave  : com_cs side  (reads fs_send and the descriptor, drives fd_send)
// ---------------------------------------------------------------------------
interface com_send_arb_if;
    import com_pkg::*;

    logic               fs_send;
    logic               fd_send;
    logic [BTYPE_W-1:0] send_btype;
    logic [LEN_W-1:0]   send_dlen;
    logic [ADDR_W-1:0]  send_ram_init;

    modport master (
        output fs_send, send_btype, send_dlen, send_ram_init,
        input  fd_send
    );

    modport slave (
        input  fs_send, send_btype, send_dlen, send_ram_init,
        output fd_send
    );
endinterface

// File: rtl/com_arb_pick.sv
// ---------------------------------------------------------------------------
// com_arb_pick
// Combinational winner select for the send arbiter.
//   req    in   NUM_REQ  pending requests
//   rr_ptr in   IDX_W    round-robin search start
//   valid  out  1        at least one request pending
//   idx    out  IDX_W    winning requester
// Build option: COM_SEND_ARB_PRIO_EN selects fixed priority (lowest index
// wins, rr_ptr ignored); otherwise round-robin starting at rr_ptr.
// ---------------------------------------------------------------------------
module com_arb_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);
    assign valid = |req;

`ifdef COM_SEND_ARB_PRIO_EN
    logic [IDX_W-1:0] unused_rr_ptr;
    assign unused_rr_ptr = rr_ptr;

    // Walk downwards so the lowest set index is the last to overwrite idx.
    always_comb begin
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) idx = IDX_W'(k);
        end
    end
`else
    // cand[k] is the requester examined k-th when searching from rr_ptr.
    logic [IDX_W-1:0] cand [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand[gi] = IDX_W'((int'(rr_ptr) + gi) % NUM_REQ);
    end

    always_comb begin
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) idx = cand[k];
        end
    end
`endif
endmodule

// File: rtl/com_send_arb.sv
// ---------------------------------------------------------------------------
// com_send_arb
// Shares the single com_cs send channel among NUM_REQ requesters: picks one
// pending requester, latches its descriptor, runs the four-phase send
// handshake with com_cs and returns done to the winner.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_fs/req_fd  per-requester send request / done
//   req_btype, req_dlen, req_ram_init  packed per-requester descriptors
//   send           com_cs channel (master modport)
//   grant_idx      current/last granted requester
//   busy           transaction in progress (PICK..REQ_DONE)
// Build option: COM_SEND_ARB_PRIO_EN -> fixed priority arbitration.
// ---------------------------------------------------------------------------
module com_send_arb
    import com_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_fs,
    output logic [NUM_REQ-1:0]        req_fd,
    input  logic [BTYPE_W*NUM_REQ-1:0] req_btype,
    input  logic [LEN_W*NUM_REQ-1:0]  req_dlen,
    input  logic [ADDR_W*NUM_REQ-1:0] req_ram_init,
    com_send_arb_if.master            send,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      busy
);
    send_state_e        state_q, state_d;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [BTYPE_W-1:0] btype_q;
    logic [LEN_W-1:0]   dlen_q;
    logic [ADDR_W-1:0]  init_q;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    logic [BTYPE_W-1:0] btype_arr [NUM_REQ];
    logic [LEN_W-1:0]   dlen_arr  [NUM_REQ];
    logic [ADDR_W-1:0]  init_arr  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign btype_arr[gi] = req_btype[gi*BTYPE_W +: BTYPE_W];
        assign dlen_arr[gi]  = req_dlen[gi*LEN_W +: LEN_W];
        assign init_arr[gi]  = req_ram_init[gi*ADDR_W +: ADDR_W];
    end

    com_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req_fs),
        .rr_ptr (rr_q),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

`ifdef COM_SEND_ARB_PRIO_EN
    assign rr_d = '0;
`else
    // Next search starts just after the winner, wrapping at NUM_REQ-1.
    assign rr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            btype_q <= '0;
            dlen_q  <= '0;
            init_q  <= '0;
        end else begin
            state_q <= state_d;
            // If every request vanished before PICK the previous grant is kept.
            if (state_q == ST_PICK && pick_valid) begin
                grant_q <= pick_idx;
            end
            // Descriptor is captured once; later requester changes are ignored.
            if (state_q == ST_LATCH) begin
                btype_q <= btype_arr[grant_q];
                dlen_q  <= dlen_arr[grant_q];
                init_q  <= init_arr[grant_q];
                rr_q    <= rr_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     state_d = ST_WAIT;
            ST_WAIT:     if (|req_fs) state_d = ST_PICK;
            ST_PICK:     state_d = ST_LATCH;
            ST_LATCH:    state_d = ST_SEND;
            ST_SEND:     if (send.fd_send) state_d = ST_DROP;
            ST_DROP:     if (!send.fd_send) state_d = ST_REQ_DONE;
            ST_REQ_DONE: if (!req_fs[grant_q]) state_d = ST_WAIT;
            default:     state_d = ST_IDLE;
        endcase
    end

    // All handshake outputs decode the registered state only.
    assign send.fs_send       = (state_q == ST_SEND);
    assign send.send_btype    = btype_q;
    assign send.send_dlen     = dlen_q;
    assign send.send_ram_init = init_q;
    assign req_fd             = (state_q == ST_REQ_DONE) ? (NUM_REQ'(1) << grant_q) : '0;
    assign busy               = (state_q == ST_PICK)  || (state_q == ST_LATCH) ||
                                (state_q == ST_SEND)  || (state_q == ST_DROP)  ||
                                (state_q == ST_REQ_DONE);
    assign grant_idx          = grant_q;
endmodule
